// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, producing diff = a - b (mod 2^WIDTH) and the final borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic w_x, w_y, w_z;
    logic w_d, w_bnext;
    logic w_accept;
    logic w_last;

    // Full-subtractor cell on the current LSBs and the stored borrow
    assign w_x     = r_ra[0];
    assign w_y     = r_rb[0];
    assign w_z     = r_br;
    assign w_d     = w_x ^ w_y ^ w_z;
    assign w_bnext = (~w_x & w_y) | (~(w_x ^ w_y) & w_z);

    assign w_accept = i_start && (r_state != S_SHIFT);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_SHIFT;
            S_SHIFT: if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = i_start ? S_SHIFT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_ra  <= i_a;
            r_rb  <= i_b;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_ra   <= r_ra >> 1;
            r_rb   <= r_rb >> 1;
            r_br   <= w_bnext;
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            // Counter parks at 0 after the last bit so it never exceeds WIDTH-1
            r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) r_bout <= w_bnext;
        end
    end

    assign o_busy = (r_state == S_SHIFT);
    assign o_done = (r_state == S_DONE);
    assign o_diff = r_diff;
    assign o_bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) plus an exhaustive WIDTH=4 sweep,
// with expected results queued at stimulus time and popped at each done.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       s8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       s4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(s8), .i_a(a8), .i_b(b8),
        .o_busy(busy8), .o_done(done8), .o_diff(diff8), .o_bout(bout8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(s4), .i_a(a4), .i_b(b4),
        .o_busy(busy4), .o_done(done4), .o_diff(diff4), .o_bout(bout4)
    );

    int         total = 0;
    int         bad   = 0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];
    int         n, nb, dcnt;
    logic [8:0] e8;
    logic [4:0] e4;
    logic [7:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse; returns at the negedge after the accepting edge
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input bit push);
        logic [7:0] d;
        d = a - b;
        @(negedge clk);
        s8 = 1'b1; a8 = a; b8 = b;
        if (push) q8.push_back({(a < b) ? 1'b1 : 1'b0, d});
        @(posedge clk);
        @(negedge clk);
        s8 = 1'b0;
    endtask

    // Counts edges until done (bounded), and busy samples seen on the way
    task automatic wait8(output int edges, output int busys);
        edges = 0; busys = 0;
        while (done8 !== 1'b1 && edges < 40) begin
            if (busy8 === 1'b1) busys++;
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic pop8(input string tag);
        chk({tag, "_qsize"}, (q8.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (q8.size() > 0) begin
            e8 = q8.pop_front();
            chk({tag, "_diff"}, {24'd0, diff8}, {24'd0, e8[7:0]});
            chk({tag, "_bout"}, {31'd0, bout8}, {31'd0, e8[8]});
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b);
        start8(a, b, 1'b1);
        wait8(n, nb);
        chk({tag, "_lat"}, n, 32'd8);
        chk({tag, "_busycyc"}, nb, 32'd8);
        pop8(tag);
    endtask

    initial begin
        rst = 1'b1;
        s8 = 1'b0; a8 = '0; b8 = '0;
        s4 = 1'b0; a4 = '0; b4 = '0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_bout", {31'd0, bout8}, 32'd0);
        rst = 1'b0;

        op8("basic", 8'd5, 8'd3);
        op8("borrow", 8'd3, 8'd5);

        // Idle holds result and flags stay low
        held = diff8;
        repeat (3) @(negedge clk);
        chk("hold_diff", {24'd0, diff8}, {24'd0, held});
        chk("hold_done", {31'd0, done8}, 32'd0);
        chk("hold_busy", {31'd0, busy8}, 32'd0);

        // Asynchronous reset between edges mid-operation
        start8(8'd3, 8'd5, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy8}, 32'd0);
        chk("arst_done", {31'd0, done8}, 32'd0);
        chk("arst_diff", {24'd0, diff8}, 32'd0);
        chk("arst_bout", {31'd0, bout8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) dcnt++;
        end
        chk("arst_nodone", dcnt, 32'd0);
        op8("after_rst", 8'd10, 8'd4);

        op8("zero", 8'h00, 8'h00);
        op8("0_ff", 8'h00, 8'hFF);
        op8("ff_ff", 8'hFF, 8'hFF);
        op8("80_01", 8'h80, 8'h01);

        // Start pulse at E3 is ignored; second op accepted in the DONE cycle
        start8(8'd9, 8'd4, 1'b1);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        s8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
        @(posedge clk); @(negedge clk);
        s8 = 1'b0;
        wait8(n, nb);
        chk("ign_lat", n, 32'd5);
        pop8("ign");
        s8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
        q8.push_back({1'b0, 8'd0});
        @(posedge clk); @(negedge clk);
        s8 = 1'b0;
        chk("b2b_busy", {31'd0, busy8}, 32'd1);
        chk("b2b_done", {31'd0, done8}, 32'd0);
        wait8(n, nb);
        chk("b2b_lat", n, 32'd8);
        pop8("b2b");

        // Exhaustive WIDTH=4 with start held high: every result 5 cycles apart
        @(negedge clk);
        s4 = 1'b1; a4 = 4'd0; b4 = 4'd0;
        q4.push_back({1'b0, 4'd0});
        for (int i = 0; i < 256; i++) begin
            n = 0;
            do begin
                @(posedge clk);
                @(negedge clk);
                n++;
            end while (done4 !== 1'b1 && n < 20);
            chk("x4_period", n, 32'd5);
            if (q4.size() > 0) begin
                e4 = q4.pop_front();
                chk("x4_diff", {28'd0, diff4}, {28'd0, e4[3:0]});
                chk("x4_bout", {31'd0, bout4}, {31'd0, e4[4]});
            end else begin
                chk("x4_qsize", 32'd0, 32'd1);
            end
            if (i < 255) begin
                logic [3:0] na, nbv, nd;
                na  = 4'((i + 1) >> 4);
                nbv = 4'((i + 1) & 15);
                nd  = na - nbv;
                a4 = na; b4 = nbv;
                q4.push_back({(na < nbv) ? 1'b1 : 1'b0, nd});
            end else begin
                s4 = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
